sim_run_controller: RTL and testbench
=====================================

Name: sim_run_controller

Overview:
- Synthesisable run controller that sequences the CPU core's reset, supervises a test run and reports the result. It replaces the fixed-delay reset and fixed-time stop used by bench-level CPU runs.
- Sits between the bench/board reset and `cpu_top`'s reset.
- Counts cycles and retired instructions.
- Detects the RISC-V tohost completion write, decodes pass/fail, and flags timeouts.
- Parametrised in datapath width, reset hold length, timeout and tohost address.

Parameters:
- XLEN, 32, width of memory write address/data buses.
- CNT_W, 32, width of cycle and instret counters.
- RESET_CYCLES, 2, clock edges cpu_rst stays asserted after rst release; must be >=1.
- MAX_CYCLES, 50, RUN-state cycle budget before timeout; 0 disables the timeout.
- TOHOST_ADDR, 32'h0000_0FFC, byte address of the tohost word.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset of this block.
- retire_valid  input  1  one instruction retired this cycle (WB stage).
- mem_wr_en  input  1  data-memory store strobe.
- mem_wr_addr  input  XLEN  store byte address.
- mem_wr_data  input  XLEN  store data.
- cpu_rst  output  1  reset to the CPU core, active-high.
- run_state  output  2  00 HOLD, 01 RUN, 10 DONE, 11 TIMEOUT.
- done  output  1  run finished by tohost write (sticky).
- pass  output  1  tohost value was 1 (valid when done).
- fail_code  output  XLEN-1  tohost value >> 1 (valid when done).
- timeout  output  1  cycle budget exhausted (sticky).
- cycle_count  output  CNT_W  cycles spent in RUN.
- instret_count  output  CNT_W  instructions retired in RUN.

Behaviour:
- All outputs are registered; no combinational input-to-output paths.
- Reset (rst=1, async):
  - run_state=HOLD, cpu_rst=1.
  - done=0, pass=0, timeout=0.
  - fail_code=0, cycle_count=0, instret_count=0.
  - Internal hold counter=0.
  - Takes effect immediately, including mid-run; all results are discarded.
- HOLD:
  - Hold counter increments each edge.
  - On the edge where hold counter == RESET_CYCLES-1: run_state<=RUN and cpu_rst<=0.
  - With default RESET_CYCLES=2, cpu_rst falls after the 2nd rising edge following rst release.
  - Inputs are ignored in HOLD.
- RUN, per edge:
  - cycle_count += 1.
  - instret_count += retire_valid.
- Tohost hit = mem_wr_en && mem_wr_addr==TOHOST_ADDR && mem_wr_data!=0.
  - On hit: run_state<=DONE, done<=1, pass<=(mem_wr_data==1), fail_code<=mem_wr_data[XLEN-1:1], cpu_rst<=1.
  - A tohost write of 0 is ignored; the CPU keeps running.
  - A store to any other address is ignored.
- Timeout:
  - Condition: MAX_CYCLES!=0, no hit this cycle, and cycle_count==MAX_CYCLES-1.
  - Action: run_state<=TIMEOUT, timeout<=1, cpu_rst<=1.
  - cycle_count therefore reads MAX_CYCLES in TIMEOUT.
- Simultaneous events on the terminating edge:
  - Hit and timeout in the same cycle: hit wins (DONE, timeout=0).
  - The terminating edge still counts that cycle, and its retire_valid.
- DONE and TIMEOUT:
  - Both are terminal until rst.
  - Counters freeze and all inputs are ignored.
  - cpu_rst is held at 1 so the core is frozen.
  - done and timeout are never both 1.
- Counters saturate at all-ones; they never wrap.

Test Plan:
- Reset sequencing: rst=1 for 2 cycles, then release.
  - Required: cpu_rst=1 through 2 edges after release, then 0.
  - Required: run_state 00→01; counters 0.
- Pass: after RUN entry, 10 retire pulses over 20 cycles, then a store of 1 to 0xFFC on cycle 21.
  - Required: run_state=DONE, done=1, pass=1, fail_code=0.
  - Required: cycle_count=21, instret_count=10, cpu_rst=1.
- Fail, with filtering: a store of 0 to 0xFFC, a store of 7 to 0xFF8, then a store of 7 to 0xFFC.
  - Required: only the last store terminates.
  - Required: done=1, pass=0, fail_code=3.
- Timeout: MAX_CYCLES=50 with no tohost store.
  - Required: run_state=TIMEOUT after the 50th RUN cycle, timeout=1, done=0, cycle_count=50.
  - Required: later stores of 1 to 0xFFC change nothing.
- Simultaneous: a store of 1 to 0xFFC on exactly the 50th RUN cycle, together with retire_valid=1.
  - Required: DONE, pass=1, timeout=0, cycle_count=50, and that retire counted.
- Mid-run reset: assert rst asynchronously between edges during RUN at cycle 30.
  - Required: cpu_rst=1, run_state=HOLD and counters=0 immediately, with no wait for a clock edge.
  - Required: after release, a full reset sequence and a clean rerun.

Source files
------------

// File: rtl/sim_run_if.sv
// Bus between the run controller and the bench/CPU side: retire and store
// monitoring in, run status and counters out.
interface sim_run_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             retire_valid;
  logic             mem_wr_en;
  logic [XLEN-1:0]  mem_wr_addr;
  logic [XLEN-1:0]  mem_wr_data;
  logic             cpu_rst;
  logic [1:0]       run_state;
  logic             done;
  logic             pass;
  logic [XLEN-2:0]  fail_code;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;

  modport master (
    output retire_valid, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  cpu_rst, run_state, done, pass, fail_code, timeout, cycle_count, instret_count
  );

  modport slave (
    input  retire_valid, mem_wr_en, mem_wr_addr, mem_wr_data,
    output cpu_rst, run_state, done, pass, fail_code, timeout, cycle_count, instret_count
  );
endinterface

// File: rtl/sim_run_controller.sv
// Run controller: sequences the CPU reset, counts cycles/retires during the run,
// and terminates on a tohost write or when the cycle budget runs out.
module sim_run_controller #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     CNT_W        = 32,
  parameter int unsigned     RESET_CYCLES = 2,
  parameter int unsigned     MAX_CYCLES   = 50,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(32'h0000_0FFC)
) (
  input logic      clk,
  input logic      rst,
  sim_run_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);
  localparam bit                TMO_EN    = (MAX_CYCLES != 0);

  typedef enum logic [1:0] {
    StHold    = 2'b00,
    StRun     = 2'b01,
    StDone    = 2'b10,
    StTimeout = 2'b11
  } state_e;

  state_e            state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              pass_q;
  logic [XLEN-2:0]   fail_code_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  cycle_cnt_q;
  logic [CNT_W-1:0]  instret_cnt_q;
  logic              hit;
  logic              budget_out;

  // Zero tohost writes are not completions; the core keeps running.
  assign hit = bus.mem_wr_en && (bus.mem_wr_addr == TOHOST_ADDR) && (bus.mem_wr_data != '0);
  assign budget_out = TMO_EN && (cycle_cnt_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StHold;
      hold_cnt_q    <= '0;
      cpu_rst_q     <= 1'b1;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= '0;
      timeout_q     <= 1'b0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StHold: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (hold_cnt_q == HOLD_LAST) begin
            state_q   <= StRun;
            cpu_rst_q <= 1'b0;
          end
        end
        StRun: begin
          // The terminating edge still counts its own cycle and retire.
          if (cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + 1'b1;
          if (bus.retire_valid && (instret_cnt_q != '1)) instret_cnt_q <= instret_cnt_q + 1'b1;
          if (hit) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            pass_q      <= (bus.mem_wr_data == XLEN'(1));
            fail_code_q <= bus.mem_wr_data[XLEN-1:1];
            cpu_rst_q   <= 1'b1;
          end else if (budget_out) begin
            state_q   <= StTimeout;
            timeout_q <= 1'b1;
            cpu_rst_q <= 1'b1;
          end
        end
        StDone, StTimeout: begin
          cpu_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cpu_rst       = cpu_rst_q;
  assign bus.run_state     = state_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.fail_code     = fail_code_q;
  assign bus.timeout       = timeout_q;
  assign bus.cycle_count   = cycle_cnt_q;
  assign bus.instret_count = instret_cnt_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: directed scenarios plus randomized runs, all
// checked every cycle against a behavioural run model.
module tb_sim_run_controller;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned RST_CY = 2;
  localparam int unsigned MAX_CY = 50;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sim_run_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  sim_run_controller #(
    .XLEN(XLEN), .CNT_W(CNT_W), .RESET_CYCLES(RST_CY), .MAX_CYCLES(MAX_CY),
    .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: edges seen since release, and the run phase as plain flags.
  int unsigned m_edges;
  bit          m_running, m_done, m_tmo, m_pass;
  logic [30:0] m_fail;
  longint      m_cyc, m_ins;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_edges = 0; m_running = 0; m_done = 0; m_tmo = 0; m_pass = 0;
    m_fail = '0; m_cyc = 0; m_ins = 0;
  endfunction

  function automatic void model_step(input bit ret, input bit wen, input logic [31:0] a,
                                     input logic [31:0] d);
    if (m_done || m_tmo) return;
    if (!m_running) begin
      m_edges++;
      if (m_edges == RST_CY) m_running = 1;
      return;
    end
    m_cyc++;
    if (ret) m_ins++;
    if (wen && a == TOHOST && d != 0) begin
      m_running = 0; m_done = 1; m_pass = (d == 1); m_fail = d[31:1];
    end else if (MAX_CY != 0 && m_cyc == MAX_CY) begin
      m_running = 0; m_tmo = 1;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [1:0] exp_state;
    exp_state = m_done ? 2'd2 : m_tmo ? 2'd3 : m_running ? 2'd1 : 2'd0;
    check_eq({tag, ".state"},   64'(bus.run_state),     64'(exp_state));
    check_eq({tag, ".cpu_rst"}, 64'(bus.cpu_rst),       64'(!m_running));
    check_eq({tag, ".done"},    64'(bus.done),          64'(m_done));
    check_eq({tag, ".pass"},    64'(bus.pass),          64'(m_pass));
    check_eq({tag, ".fail"},    64'(bus.fail_code),     64'(m_fail));
    check_eq({tag, ".timeout"}, 64'(bus.timeout),       64'(m_tmo));
    check_eq({tag, ".cycles"},  64'(bus.cycle_count),   64'(m_cyc));
    check_eq({tag, ".instret"}, 64'(bus.instret_count), 64'(m_ins));
  endtask

  // Called at a negedge: drive inputs, take one rising edge, check at the next negedge.
  task automatic step(input string tag, input bit ret, input bit wen, input logic [31:0] a,
                      input logic [31:0] d);
    bus.retire_valid = ret;
    bus.mem_wr_en    = wen;
    bus.mem_wr_addr  = a;
    bus.mem_wr_data  = d;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(ret, wen, a, d);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, '0, '0);
  endtask

  // Two cycles of reset, release, then the hold sequence into RUN.
  task automatic restart(input string tag);
    rst = 1'b1;
    model_reset();
    idle({tag, ".rst"}, 2);
    rst = 1'b0;
    idle({tag, ".hold"}, RST_CY);
  endtask

  initial begin
    bus.retire_valid = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_wr_addr  = '0;
    bus.mem_wr_data  = '0;
    model_reset();
    @(negedge clk);
    check_all("por");

    // Reset sequencing.
    idle("rstseq.rst", 1);
    rst = 1'b0;
    step("rstseq.e1", 1'b1, 1'b1, TOHOST, 32'd1);
    check_eq("rstseq.e1_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    idle("rstseq.e2", 1);
    check_eq("rstseq.e2_cpu_rst", 64'(bus.cpu_rst), 64'd0);
    check_eq("rstseq.e2_state", 64'(bus.run_state), 64'd1);

    // Pass: 10 retires over 20 cycles, then tohost=1 on cycle 21.
    for (int i = 0; i < 20; i++) step("pass.run", (i % 2) == 0, 1'b0, '0, '0);
    step("pass.hit", 1'b0, 1'b1, TOHOST, 32'd1);
    check_eq("pass.state", 64'(bus.run_state), 64'd2);
    check_eq("pass.cycles", 64'(bus.cycle_count), 64'd21);
    check_eq("pass.instret", 64'(bus.instret_count), 64'd10);
    check_eq("pass.pass", 64'(bus.pass), 64'd1);
    for (int i = 0; i < 4; i++) step("pass.frozen", 1'b1, 1'b1, TOHOST, 32'd5);

    // Fail with filtering of zero and wrong-address stores.
    restart("fail");
    step("fail.zero", 1'b1, 1'b1, TOHOST, 32'd0);
    step("fail.addr", 1'b1, 1'b1, 32'h0000_0FF8, 32'd7);
    check_eq("fail.still_run", 64'(bus.run_state), 64'd1);
    step("fail.hit", 1'b0, 1'b1, TOHOST, 32'd7);
    check_eq("fail.done", 64'(bus.done), 64'd1);
    check_eq("fail.pass", 64'(bus.pass), 64'd0);
    check_eq("fail.code", 64'(bus.fail_code), 64'd3);

    // Timeout with later stores ignored.
    restart("tmo");
    for (int i = 0; i < MAX_CY; i++) step("tmo.run", 1'($urandom_range(0, 1)), 1'b0, '0, '0);
    check_eq("tmo.state", 64'(bus.run_state), 64'd3);
    check_eq("tmo.cycles", 64'(bus.cycle_count), 64'(MAX_CY));
    check_eq("tmo.done", 64'(bus.done), 64'd0);
    for (int i = 0; i < 3; i++) step("tmo.late", 1'b1, 1'b1, TOHOST, 32'd1);
    check_eq("tmo.timeout", 64'(bus.timeout), 64'd1);

    // Hit on exactly the last budgeted cycle: hit wins, retire counted.
    restart("sim");
    for (int i = 0; i < MAX_CY - 1; i++) step("sim.run", 1'b0, 1'b0, '0, '0);
    step("sim.hit", 1'b1, 1'b1, TOHOST, 32'd1);
    check_eq("sim.state", 64'(bus.run_state), 64'd2);
    check_eq("sim.timeout", 64'(bus.timeout), 64'd0);
    check_eq("sim.cycles", 64'(bus.cycle_count), 64'(MAX_CY));
    check_eq("sim.instret", 64'(bus.instret_count), 64'd1);

    // Asynchronous reset between edges at RUN cycle 30.
    restart("mid");
    for (int i = 0; i < 30; i++) step("mid.run", 1'b1, 1'b0, '0, '0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("mid.async");
    check_eq("mid.async_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    check_eq("mid.async_cycles", 64'(bus.cycle_count), 64'd0);
    @(negedge clk);
    idle("mid.rst", 1);
    rst = 1'b0;
    step("mid.h1", 1'b0, 1'b0, '0, '0);
    check_eq("mid.h1_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    step("mid.h2", 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) step("mid.rerun", 1'b1, 1'b0, '0, '0);
    step("mid.hit", 1'b0, 1'b1, TOHOST, 32'd1);
    check_eq("mid.cycles", 64'(bus.cycle_count), 64'd6);
    check_eq("mid.instret", 64'(bus.instret_count), 64'd5);

    // Randomized runs: mixed stores, some terminating, some timing out.
    for (int r = 0; r < 6; r++) begin
      restart("rnd");
      for (int i = 0; i < 70; i++) begin
        logic [31:0] a, d;
        int unsigned sa, sd;
        sa = $urandom_range(0, 3);
        sd = $urandom_range(0, 3);
        a = (sa == 0) ? TOHOST : (sa == 1) ? TOHOST - 32'd4 : $urandom;
        d = (sd == 0) ? 32'd0 : (sd == 1) ? 32'd1 : 32'($urandom_range(2, 255));
        step("rnd", 1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0, a, d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
